ddfs_sweep_gen: RTL

//  Parametrised DDFS core driving the external DAC; successor to the fixed 7-bit-FW / 12-bit-out DDFS.
//  - Widths and LUT depth are parameters; adds a sawtooth waveform.
//  - Adds a linear frequency-sweep (chirp) FSM and phase-truncation dithering.
//  - Frequency-word changes are applied only at phase wrap, so they are glitch-free.
//  - Sits between the front-panel control register block and the DAC interface.

---
 rtl/ddfs_pkg.sv | 28 ++
 rtl/ddfs_sweep_gen_if.sv | 35 +++
 rtl/ddfs_sine_lut.sv | 49 ++++
 rtl/ddfs_sweep_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ddfs_pkg.sv
// ddfs_pkg: shared definitions for the DDFS sweep generator.
//   - wave_sel encodings
//   - sweep FSM state type
//   - dither LFSR seed / Galois tap mask (x^16+x^14+x^13+x^11+1)
//   - midscale() helper for the offset-binary reset / centre value
package ddfs_pkg;

    localparam logic [1:0] WAVE_SQR = 2'b00;
    localparam logic [1:0] WAVE_TRI = 2'b01;
    localparam logic [1:0] WAVE_SIN = 2'b10;
    localparam logic [1:0] WAVE_SAW = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } sweep_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Offset-binary zero for a w-bit DAC.
    function automatic int midscale(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/ddfs_sweep_gen_if.sv
// ddfs_sweep_gen_if: control/status bundle between the front-panel register
// block (master) and the DDFS core (slave).
//   master drives: en, wave_sel, mirror_x, mirror_y, freq_cntrl, fw, fw_step,
//                  fw_stop, sweep_start
//   slave drives:  sweep_busy, phase_wrap, q_valid, q
interface ddfs_sweep_gen_if #(
    parameter int FW_W  = 16,
    parameter int DAC_W = 12
);
    logic              en;
    logic [1:0]        wave_sel;
    logic              mirror_x;
    logic              mirror_y;
    logic [2:0]        freq_cntrl;
    logic [FW_W-1:0]   fw;
    logic [FW_W-1:0]   fw_step;
    logic [FW_W-1:0]   fw_stop;
    logic              sweep_start;
    logic              sweep_busy;
    logic              phase_wrap;
    logic              q_valid;
    logic [DAC_W-1:0]  q;

    modport master (
        output en, wave_sel, mirror_x, mirror_y, freq_cntrl,
               fw, fw_step, fw_stop, sweep_start,
        input  sweep_busy, phase_wrap, q_valid, q
    );

    modport slave (
        input  en, wave_sel, mirror_x, mirror_y, freq_cntrl,
               fw, fw_step, fw_stop, sweep_start,
        output sweep_busy, phase_wrap, q_valid, q
    );
endinterface

// File: rtl/ddfs_sine_lut.sv
// ddfs_sine_lut: quarter-wave sine ROM with a one-cycle registered read.
//   clk, rst_n : clock, async active-low reset (clears the read register)
//   addr       : quarter-wave address, 0 = phase 0, 2^LUT_AW-1 = just below pi/2
//   data       : round(2^(DAC_W-1) * sin(pi/2 * addr / 2^LUT_AW)), clamped to
//                2^(DAC_W-1)-1 so midscale + data never exceeds full scale
// Contents are computed at elaboration from LUT_AW/DAC_W, so resizing the
// core needs no regenerated data file.
module ddfs_sine_lut #(
    parameter int LUT_AW = 8,
    parameter int DAC_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LUT_AW-1:0] addr,
    output logic [DAC_W-2:0]  data
);
    localparam int DEPTH = 1 << LUT_AW;

    // Taylor series to x^19; x <= pi/2 keeps the error far below 1 LSB.
    function automatic logic [DAC_W-2:0] sine_entry(input int idx);
        real x, term, s, v;
        int  r, top;
        x    = 1.5707963267948966 * $itor(idx) / $itor(DEPTH);
        term = x;
        s    = x;
        for (int k = 1; k <= 9; k++) begin
            term = -term * x * x / $itor((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        v   = s * $itor(1 << (DAC_W - 1));
        r   = $rtoi(v + 0.5);
        top = (1 << (DAC_W - 1)) - 1;
        if (r > top) r = top;
        if (r < 0)   r = 0;
        return (DAC_W-1)'(r);
    endfunction

    logic [DAC_W-2:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [DAC_W-2:0] ENTRY = sine_entry(i);
        assign rom[i] = ENTRY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data <= '0;
        else        data <= rom[addr];
    end
endmodule

// File: rtl/ddfs_sweep_gen.sv
// ddfs_sweep_gen: parametrised DDFS core with linear frequency sweep.
//   clk, rst_n : clock, async active-low reset
//   bus        : ddfs_sweep_gen_if.slave (controls in; sweep_busy, phase_wrap,
//                q_valid, q out)
// Pipeline: prescaler tick -> acc (stage 0) -> waveform/LUT regs (stage 1)
//   -> q (stage 2). q is re-registered every cycle so wave_sel/mirror changes
//   propagate without a tick; q_valid marks tick-derived samples only.
// The frequency word in use (fw_cur) only changes on a phase wrap, or while
// idle and disabled, so the output never jumps mid-period.
// Optional build macro DDFS_DITHER_EN: LFSR phase dither on the sine path.
module ddfs_sweep_gen
    import ddfs_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int FW_W    = 16,
    parameter int DAC_W   = 12,
    parameter int LUT_AW  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    ddfs_sweep_gen_if.slave bus
);
    localparam int PW = LUT_AW + 2;
    localparam logic [DAC_W-1:0] MID = DAC_W'(midscale(DAC_W));

    // ---------------- prescaler ----------------
    // presc_lim is latched at each clear so freq_cntrl changes never cut a
    // prescale period short.
    logic [6:0] presc, presc_lim;
    logic       tick;

    assign tick = bus.en && (presc == presc_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            presc_lim <= '0;
        end else if (bus.en) begin
            if (tick) begin
                presc     <= '0;
                presc_lim <= (7'd1 << bus.freq_cntrl) - 7'd1;
            end else begin
                presc <= presc + 7'd1;
            end
        end
    end

    // ---------------- accumulator ----------------
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W:0]   acc_sum;
    logic               phase_wrap;
    logic [FW_W-1:0]    fw_cur;

    assign acc_sum = {1'b0, acc} + (PHASE_W+1)'(fw_cur);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            phase_wrap <= 1'b0;
        end else if (tick) begin
            acc        <= acc_sum[PHASE_W-1:0];
            phase_wrap <= acc_sum[PHASE_W];
        end else begin
            phase_wrap <= 1'b0;
        end
    end

    // ---------------- sweep FSM ----------------
    sweep_state_t    state;
    logic            sweep_busy;
    logic [FW_W:0]   ramp_sum;

    // One extra bit so a step past full scale clamps to fw_stop instead of wrapping.
    assign ramp_sum = {1'b0, fw_cur} + {1'b0, bus.fw_step};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fw_cur     <= '0;
            sweep_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.en || phase_wrap) fw_cur <= bus.fw;
                    if (bus.sweep_start) begin
                        state      <= RAMP;
                        sweep_busy <= 1'b1;
                    end
                end
                RAMP: begin
                    if (!bus.sweep_start) begin
                        state      <= IDLE;
                        sweep_busy <= 1'b0;
                    end else if (phase_wrap) begin
                        // A zero step or a stop at/below fw_cur lands on fw_stop at once.
                        if (bus.fw_step == '0 || ramp_sum >= {1'b0, bus.fw_stop}) begin
                            fw_cur <= bus.fw_stop;
                            state  <= HOLD;
                        end else begin
                            fw_cur <= ramp_sum[FW_W-1:0];
                        end
                    end
                end
                HOLD: begin
                    if (!bus.sweep_start) begin
                        state      <= IDLE;
                        sweep_busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    sweep_busy <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- stage 0: phase decode ----------------
    logic [DAC_W-1:0] ph_top;
    logic [DAC_W-1:0] tri_val, sqr_val, nonsin;
    logic [PW-1:0]    sin_p;
    logic [LUT_AW-1:0] lut_addr;

    assign ph_top  = acc[PHASE_W-1 -: DAC_W] ^ {DAC_W{bus.mirror_x}};
    assign sqr_val = ph_top[DAC_W-1] ? '0 : {DAC_W{1'b1}};
    // Second half: 2*(max-ph) == (~ph)<<1 truncated.
    assign tri_val = ph_top[DAC_W-1] ? {~ph_top[DAC_W-2:0], 1'b0}
                                     : { ph_top[DAC_W-2:0], 1'b0};

`ifdef DDFS_DITHER_EN
    localparam int DITH_W = (PHASE_W - PW > 16) ? 16 : (PHASE_W - PW);

    logic [15:0]        lfsr;
    logic [PHASE_W-1:0] dith_phase;
    logic               dith_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    lfsr <= LFSR_SEED;
        else if (tick) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
    end

    // Dither lives below the LUT address bits; only the sine path sees it.
    assign dith_phase  = (acc ^ {PHASE_W{bus.mirror_x}}) + PHASE_W'(lfsr[DITH_W-1:0]);
    assign sin_p       = dith_phase[PHASE_W-1 -: PW];
    assign dith_unused = ^dith_phase[PHASE_W-PW-1:0];
`else
    assign sin_p = acc[PHASE_W-1 -: PW] ^ {PW{bus.mirror_x}};
`endif

    // Quadrants 1 and 3 read the quarter table backwards.
    assign lut_addr = sin_p[LUT_AW] ? ~sin_p[LUT_AW-1:0] : sin_p[LUT_AW-1:0];

    always_comb begin
        nonsin = ph_top;
        case (bus.wave_sel)
            WAVE_SQR: nonsin = sqr_val;
            WAVE_TRI: nonsin = tri_val;
            default:  nonsin = ph_top;
        endcase
    end

    // ---------------- stage 1 ----------------
    logic [DAC_W-2:0] lut_data;
    logic [1:0]       wsel_s1;
    logic             my_s1, neg_s1;
    logic [DAC_W-1:0] nonsin_s1;

    ddfs_sine_lut #(.LUT_AW(LUT_AW), .DAC_W(DAC_W)) u_lut (
        .clk  (clk),
        .rst_n(rst_n),
        .addr (lut_addr),
        .data (lut_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsel_s1   <= WAVE_SQR;
            my_s1     <= 1'b0;
            neg_s1    <= 1'b0;
            nonsin_s1 <= '0;
        end else begin
            wsel_s1   <= bus.wave_sel;
            my_s1     <= bus.mirror_y;
            neg_s1    <= sin_p[PW-1];
            nonsin_s1 <= nonsin;
        end
    end

    // ---------------- stage 2: output ----------------
    logic [DAC_W-1:0] lut_ext, sine_val, sample, dac_q;
    logic [2:0]       vld_pipe;

    assign lut_ext  = {1'b0, lut_data};
    // LUT is clamped to MID-1, so neither branch can overflow.
    assign sine_val = neg_s1 ? (MID - lut_ext) : (MID + lut_ext);
    assign sample   = (wsel_s1 == WAVE_SIN) ? sine_val : nonsin_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_q    <= MID;
            vld_pipe <= '0;
        end else begin
            dac_q    <= my_s1 ? ~sample : sample;
            vld_pipe <= {vld_pipe[1:0], tick};
        end
    end

    assign bus.q          = dac_q;
    assign bus.q_valid    = vld_pipe[2];
    assign bus.phase_wrap = phase_wrap;
    assign bus.sweep_busy = sweep_busy;

endmodule
